// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and slot layout for the hazard scoreboard
package hazard_pkg;
    localparam int AW_DEF = 5;
    localparam int TW_DEF = 2;
    localparam logic [1:0] FWD_GRF  = 2'd0;
    localparam logic [1:0] FWD_NEAR = 2'd1;
    localparam logic [1:0] FWD_FAR  = 2'd2;
    localparam logic [TW_DEF-1:0] TUSE_NONE = 2'd3;
    typedef struct packed {
        logic [AW_DEF-1:0] dst;
        logic [TW_DEF-1:0] tnew;
        logic [AW_DEF-1:0] rs;
        logic [AW_DEF-1:0] rt;
    } slot_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: D-stage request and hazard/forwarding response bundle
interface hazard_scoreboard_if #(
    parameter int AW = hazard_pkg::AW_DEF,
    parameter int TW = hazard_pkg::TW_DEF
);
    logic          d_valid;
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic [TW-1:0] d_tuse_rs;
    logic [TW-1:0] d_tuse_rt;
    logic [AW-1:0] d_dst;
    logic [TW-1:0] d_tnew;
    logic          ext_stall;
    logic          stall;
    logic [1:0]    fwd_d_rs;
    logic [1:0]    fwd_d_rt;
    logic [1:0]    fwd_e_rs;
    logic [1:0]    fwd_e_rt;
    logic [AW-1:0] e_dst;
    logic [AW-1:0] m_dst;
    logic [AW-1:0] w_dst;
    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, ext_stall,
        input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, e_dst, m_dst, w_dst
    );
    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew, ext_stall,
        output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, e_dst, m_dst, w_dst
    );
endinterface

// File: rtl/hazard_slot.sv
// hazard_slot: one tracked pipeline slot; loads or bubbles, optionally aging tnew
module hazard_slot #(
    parameter int AW = hazard_pkg::AW_DEF,
    parameter int TW = hazard_pkg::TW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_dec,
    input  logic [AW-1:0] i_dst,
    input  logic [TW-1:0] i_tnew,
    input  logic [AW-1:0] i_rs,
    input  logic [AW-1:0] i_rt,
    output logic [AW-1:0] o_dst,
    output logic [TW-1:0] o_tnew,
    output logic [AW-1:0] o_rs,
    output logic [AW-1:0] o_rt
);
    logic [AW-1:0] r_dst, r_rs, r_rt;
    logic [TW-1:0] r_tnew;

    always_ff @(posedge clk) begin
        if (reset || !i_load) begin
            r_dst  <= '0;
            r_tnew <= '0;
            r_rs   <= '0;
            r_rt   <= '0;
        end else begin
            r_dst  <= i_dst;
            r_tnew <= (i_dec && i_tnew != '0) ? i_tnew - TW'(1) : i_tnew;
            r_rs   <= i_rs;
            r_rt   <= i_rt;
        end
    end

    assign o_dst  = r_dst;
    assign o_tnew = r_tnew;
    assign o_rs   = r_rs;
    assign o_rt   = r_rt;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks E/M/W destinations and derives stall plus D/E forwarding selects
module hazard_scoreboard #(
    parameter int AW = hazard_pkg::AW_DEF,
    parameter int TW = hazard_pkg::TW_DEF
) (
    input logic clk,
    input logic reset,
    hazard_scoreboard_if.slave bus
);
    import hazard_pkg::*;

    // index 0 = E, 1 = M, 2 = W; each slot is fed by the one before it
    logic [2:0][AW-1:0] w_dst, w_rs, w_rt, w_in_dst, w_in_rs, w_in_rt;
    logic [2:0][TW-1:0] w_tnew, w_in_tnew;
    logic w_haz_rs, w_haz_rt, w_stall, w_e_load, w_unused;

    function automatic logic f_match(input logic [AW-1:0] s, input logic [AW-1:0] a);
        return a != '0 && s == a;
    endfunction

    function automatic logic f_haz(input logic [AW-1:0] a, input logic [TW-1:0] u,
                                   input logic [AW-1:0] ed, input logic [TW-1:0] et,
                                   input logic [AW-1:0] md, input logic [TW-1:0] mt);
        return u != TW'(TUSE_NONE) && ((f_match(ed, a) && et > u) || (f_match(md, a) && mt > u));
    endfunction

    // a matching near producer always wins, even while its result is still pending
    function automatic logic [1:0] f_sel(input logic [AW-1:0] a,
                                         input logic [AW-1:0] nd, input logic [TW-1:0] nt,
                                         input logic [AW-1:0] fd, input logic fok);
        return f_match(nd, a) ? (nt == '0 ? FWD_NEAR : FWD_GRF) :
               (f_match(fd, a) && fok) ? FWD_FAR : FWD_GRF;
    endfunction

    assign w_in_dst  = {w_dst[1], w_dst[0], bus.d_dst};
    assign w_in_tnew = {w_tnew[1], w_tnew[0], bus.d_tnew};
    assign w_in_rs   = {w_rs[1], w_rs[0], bus.d_rs};
    assign w_in_rt   = {w_rt[1], w_rt[0], bus.d_rt};

    for (genvar g = 0; g < 3; g++) begin : g_slot
        hazard_slot #(.AW(AW), .TW(TW)) u_slot (
            .clk    (clk),
            .reset  (reset),
            .i_load (g == 0 ? w_e_load : 1'b1),
            .i_dec  (g != 0),
            .i_dst  (w_in_dst[g]),
            .i_tnew (w_in_tnew[g]),
            .i_rs   (w_in_rs[g]),
            .i_rt   (w_in_rt[g]),
            .o_dst  (w_dst[g]),
            .o_tnew (w_tnew[g]),
            .o_rs   (w_rs[g]),
            .o_rt   (w_rt[g])
        );
    end

    assign w_haz_rs = f_haz(bus.d_rs, bus.d_tuse_rs, w_dst[0], w_tnew[0], w_dst[1], w_tnew[1]);
    assign w_haz_rt = f_haz(bus.d_rt, bus.d_tuse_rt, w_dst[0], w_tnew[0], w_dst[1], w_tnew[1]);
    assign w_stall  = bus.d_valid && (w_haz_rs || w_haz_rt || bus.ext_stall);
    assign w_e_load = bus.d_valid && !w_stall;
    assign w_unused = ^{w_rs[2:1], w_rt[2:1], w_tnew[2]};

    assign bus.stall    = w_stall;
    assign bus.fwd_d_rs = f_sel(bus.d_rs, w_dst[0], w_tnew[0], w_dst[1], w_tnew[1] == '0);
    assign bus.fwd_d_rt = f_sel(bus.d_rt, w_dst[0], w_tnew[0], w_dst[1], w_tnew[1] == '0);
    assign bus.fwd_e_rs = f_sel(w_rs[0], w_dst[1], w_tnew[1], w_dst[2], 1'b1);
    assign bus.fwd_e_rt = f_sel(w_rt[0], w_dst[1], w_tnew[1], w_dst[2], 1'b1);
    assign bus.e_dst    = w_dst[0];
    assign bus.m_dst    = w_dst[1];
    assign bus.w_dst    = w_dst[2];
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed load-use, branch, zero-register, ext-stall and reset scenarios
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_run = 0;
    int n_fail = 0;

    hazard_scoreboard_if bus ();

    hazard_scoreboard u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] urs, input logic [1:0] urt,
                         input logic [4:0] dst, input logic [1:0] tnew);
        bus.d_valid   = v;
        bus.d_rs      = rs;
        bus.d_rt      = rt;
        bus.d_tuse_rs = urs;
        bus.d_tuse_rt = urt;
        bus.d_dst     = dst;
        bus.d_tnew    = tnew;
        #1;
    endtask

    initial begin
        bus.ext_stall = 1'b0;
        drive(0, 0, 0, 3, 3, 0, 0);
        cyc;
        cyc;
        chk("rst_e_dst", bus.e_dst, 0);
        chk("rst_m_dst", bus.m_dst, 0);
        chk("rst_w_dst", bus.w_dst, 0);
        chk("rst_fwd_e_rs", bus.fwd_e_rs, 0);
        bus.ext_stall = 1'b1;
        drive(1, 0, 0, 3, 3, 0, 0);
        chk("rst_stall_ext", bus.stall, 1);
        bus.ext_stall = 1'b0;
        drive(0, 0, 0, 3, 3, 0, 0);
        chk("rst_stall_idle", bus.stall, 0);
        reset = 1'b0;

        // ALU producer followed by an E-stage consumer
        drive(1, 1, 2, 1, 1, 8, 1);
        chk("t1_alu_stall", bus.stall, 0);
        cyc;
        drive(1, 8, 3, 1, 3, 10, 1);
        chk("t1_use_stall", bus.stall, 0);
        chk("t1_e_dst", bus.e_dst, 8);
        chk("t1_fwd_d_rs", bus.fwd_d_rs, 0);
        cyc;
        drive(0, 0, 0, 3, 3, 0, 0);
        chk("t1_fwd_e_rs", bus.fwd_e_rs, 1);
        chk("t1_fwd_e_rt", bus.fwd_e_rt, 0);
        chk("t1_m_dst", bus.m_dst, 8);
        cyc;
        chk("t1_e_bubble", bus.e_dst, 0);
        chk("t1_w_dst", bus.w_dst, 8);
        cyc;
        cyc;

        // load-use on rt
        drive(1, 1, 0, 1, 3, 9, 2);
        cyc;
        drive(1, 5, 9, 1, 1, 11, 1);
        chk("t2_stall", bus.stall, 1);
        chk("t2_fwd_d_rt", bus.fwd_d_rt, 0);
        cyc;
        chk("t2_e_dst", bus.e_dst, 0);
        chk("t2_m_dst", bus.m_dst, 9);
        chk("t2_stall_clr", bus.stall, 0);
        cyc;
        drive(0, 0, 0, 3, 3, 0, 0);
        chk("t2_e_dst_user", bus.e_dst, 11);
        chk("t2_fwd_e_rt", bus.fwd_e_rt, 2);
        chk("t2_fwd_e_rs", bus.fwd_e_rs, 0);
        cyc;
        cyc;
        cyc;

        // ALU producer followed by a D-stage branch
        drive(1, 1, 0, 1, 3, 4, 1);
        cyc;
        drive(1, 4, 6, 0, 0, 0, 0);
        chk("t3_stall", bus.stall, 1);
        chk("t3_fwd_d_rs_stale", bus.fwd_d_rs, 0);
        cyc;
        chk("t3_stall_clr", bus.stall, 0);
        chk("t3_fwd_d_rs", bus.fwd_d_rs, 2);
        chk("t3_fwd_d_rt", bus.fwd_d_rt, 0);
        drive(1, 4, 4, 0, 0, 0, 0);
        chk("t3_same_fwd_d_rs", bus.fwd_d_rs, 2);
        chk("t3_same_fwd_d_rt", bus.fwd_d_rt, 2);
        chk("t3_same_stall", bus.stall, 0);
        cyc;
        drive(0, 0, 0, 3, 3, 0, 0);
        chk("t3_fwd_e_rs", bus.fwd_e_rs, 2);
        chk("t3_fwd_e_rt", bus.fwd_e_rt, 2);
        cyc;
        cyc;

        // register 0 never hazards or forwards
        drive(1, 0, 0, 3, 3, 0, 2);
        cyc;
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("t4_stall", bus.stall, 0);
        chk("t4_fwd_d_rs", bus.fwd_d_rs, 0);
        chk("t4_fwd_d_rt", bus.fwd_d_rt, 0);
        cyc;
        drive(0, 0, 0, 3, 3, 0, 0);
        chk("t4_fwd_e_rs", bus.fwd_e_rs, 0);
        chk("t4_fwd_e_rt", bus.fwd_e_rt, 0);
        cyc;
        cyc;

        // external stall held for three cycles while M/W drain
        drive(1, 1, 2, 3, 3, 7, 1);
        cyc;
        bus.ext_stall = 1'b1;
        drive(1, 1, 2, 3, 3, 12, 1);
        chk("t5_stall_c1", bus.stall, 1);
        cyc;
        chk("t5_stall_c2", bus.stall, 1);
        chk("t5_e_dst", bus.e_dst, 0);
        chk("t5_m_dst", bus.m_dst, 7);
        cyc;
        chk("t5_stall_c3", bus.stall, 1);
        chk("t5_m_dst_drain", bus.m_dst, 0);
        chk("t5_w_dst", bus.w_dst, 7);
        bus.ext_stall = 1'b0;
        #1;
        chk("t5_stall_release", bus.stall, 0);
        bus.ext_stall = 1'b1;
        drive(0, 1, 2, 3, 3, 12, 1);
        chk("t5_stall_novalid", bus.stall, 0);
        bus.ext_stall = 1'b0;
        cyc;
        chk("t5_e_novalid", bus.e_dst, 0);
        chk("t5_w_drain", bus.w_dst, 0);

        // reset during a load-use stall
        drive(1, 1, 0, 1, 3, 9, 2);
        cyc;
        drive(1, 5, 9, 1, 1, 11, 1);
        chk("t6_stall", bus.stall, 1);
        reset = 1'b1;
        cyc;
        chk("t6_e_dst", bus.e_dst, 0);
        chk("t6_m_dst", bus.m_dst, 0);
        chk("t6_w_dst", bus.w_dst, 0);
        chk("t6_stall", bus.stall, 0);
        reset = 1'b0;
        cyc;
        chk("t6_user_enters", bus.e_dst, 11);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
